axil_req_arbiter: RTL
=====================

# axil_req_arbiter

Two-requester arbiter and sequencer in front of the single AXI-lite slave port of `axil_ram`. Each requester issues simple one-word read or write commands over a valid/ready port. The block grants one requester at a time, round-robin by default, and converts the command into a complete AXI-lite transaction. It returns the slave's response to the granted requester as a one-cycle pulse. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data width; must match `axil_ram`.
- `ADDR_WIDTH`, 5: byte address width; must match `axil_ram`.
- `STRB_WIDTH`, `DATA_WIDTH/8`: write strobe width.

Ports (index i in {0,1}, packed LSB-first):
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: requester i presents a command.
- `req_ready` out 2: command i accepted this cycle.
- `req_we` in 2: 1 = write, 0 = read.
- `req_addr` in 2*ADDR_WIDTH: command address.
- `req_wdata` in 2*DATA_WIDTH: write data.
- `req_wstrb` in 2*STRB_WIDTH: write strobes.
- `rsp_valid` out 2: one-cycle response pulse to requester i.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP from the slave.
- `m_axil_aw*`, `m_axil_w*`, `m_axil_b*`, `m_axil_ar*`, `m_axil_r*`: AXI-lite master port with the same signal set and widths as the `axil_ram` `s_axil_*` port. `awprot` and `arprot` are tied to 3'b000.

## Operation
- FSM states:
  - IDLE: `req_ready[g]` is combinational, where g is the arbitration winner among the asserted `req_valid` bits. On handshake the block registers we/addr/wdata/wstrb and g, then goes to WADDR if we=1, else RADDR.
  - WADDR: `awvalid` and `wvalid` are both asserted from the first cycle. Each drops independently on its own handshake. Go to WRESP once both handshakes have completed, including the case where both complete in the same cycle.
  - WRESP: `bready`=1. On the `bvalid` handshake, capture `bresp` and go to RESP.
  - RADDR: `arvalid`=1. On the `arready` handshake go to RDATA.
  - RDATA: `rready`=1. On the `rvalid` handshake, capture `rdata` and `rresp`, then go to RESP.
  - RESP: `rsp_valid[g]`=1 for exactly one cycle, then IDLE. Responses cannot be back-pressured.
- Arbitration is round-robin:
  - A lone request wins.
  - When both request, the one not granted last wins.
  - `last_grant` updates at each acceptance.
- `rsp_rdata` and `rsp_resp` hold their values until the next RESP.
- Read and write share the port; the block never overlaps a read with a write.

## Timing
- Reset: next edge goes to IDLE; `last_grant`=1, so requester 0 wins the first tie. These outputs are 0:
  - `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_resp`
  - `awvalid`, `wvalid`, `bready`, `arvalid`, `rready`
  - `awaddr`, `araddr`, `wdata`, `wstrb`
- Reset mid-transaction abandons the transaction with no response. The slave must be reset together with this block.
- Acceptance at edge N:
  - AXI valids are registered high at N+1.
  - `rsp_valid` is high the cycle after the B/R handshake.
- Next acceptance is possible no earlier than the cycle after RESP. Back-to-back throughput is one transaction per (slave latency + 3) cycles.
- AXI valids, once high, stay high with stable payload until their ready.
- `req_valid` may drop without acceptance; a losing requester waits with no timeout.

## Configuration
- `AXIL_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Requester 0 always wins a tie, `last_grant` is unused, and requester 1 can starve.
  - Undefined (default): round-robin as above.

## Structure
- Package `axil_arb_pkg` holds:
  - the FSM state enum (IDLE, WADDR, WRESP, RADDR, RDATA, RESP);
  - resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the requester count constant NREQ=2.
- Sub-module `axil_rr_arb2` holds the combinational winner and `last_grant` register, including the macro switch.
- The top level holds the FSM and the AXI channel registers.

## Test plan
- Single write: req0 writes addr 5'h04, data 2345, strb 4'hF → AW/W handshake, then B, then `rsp_valid`=2'b01, `rsp_resp`=0.
- Read-back: req1 reads addr 5'h04 → `rsp_valid`=2'b10, `rsp_rdata`=2345, `rsp_resp`=0.
- Tie, four rounds with both requesting every cycle:
  - default: grant order 0,1,0,1;
  - with `AXIL_ARB_FIXED_PRIO_EN`: 0,0,0,0.
- Slave `wready` held low 3 cycles after `awready` → `wvalid` and `wdata` stay stable, and no `bready` is asserted before the W handshake.
- Partial strobe: write 32'hAABBCCDD with strb 4'b0001 over 32'h0 → a read returns 32'h000000DD.
- Reset asserted during RDATA → all outputs 0 next cycle, no `rsp_valid`; a fresh read after reset completes normally.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared types and constants for the two-requester AXI-lite arbiter
package axil_arb_pkg;

  localparam int NREQ = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } arb_state_t;

endpackage

// File: rtl/axil_rr_arb2.sv
// rtl/axil_rr_arb2.sv - two-way winner select with last-grant memory
// AXIL_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module axil_rr_arb2
  import axil_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic            accept,
  output logic            winner
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when it is alone.
  always_comb begin
    winner = ~req_valid[0] & req_valid[1];
  end
`else
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= winner;
    end
  end

  always_comb begin
    winner = 1'b0;
    case (req_valid)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/axil_req_arbiter.sv
// rtl/axil_req_arbiter.sv - arbitrates two one-word command ports onto one AXI-lite master
// Tie policy is set in axil_rr_arb2 by AXIL_ARB_FIXED_PRIO_EN (default round-robin).
module axil_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NREQ*STRB_WIDTH-1:0] req_wstrb,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic [ADDR_WIDTH-1:0]      m_axil_awaddr,
  output logic [2:0]                 m_axil_awprot,
  output logic                       m_axil_awvalid,
  input  logic                       m_axil_awready,
  output logic [DATA_WIDTH-1:0]      m_axil_wdata,
  output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
  output logic                       m_axil_wvalid,
  input  logic                       m_axil_wready,
  input  logic [1:0]                 m_axil_bresp,
  input  logic                       m_axil_bvalid,
  output logic                       m_axil_bready,
  output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  input  logic [DATA_WIDTH-1:0]      m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  arb_state_t state_q, state_d;

  logic                  winner;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;

  logic                  grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_pend, w_pend, ar_pend;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  axil_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .accept    (accept),
    .winner    (winner)
  );

  assign accept    = (state_q == IDLE) && (|req_valid);
  assign sel_we    = winner ? req_we[1] : req_we[0];
  assign sel_addr  = winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign sel_wstrb = winner ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = sel_we ? WADDR : RADDR;
      // AW and W complete independently; leave once neither is still pending.
      WADDR: if ((!aw_pend || m_axil_awready) && (!w_pend || m_axil_wready)) state_d = WRESP;
      WRESP: if (m_axil_bvalid) state_d = RESP;
      RADDR: if (m_axil_arready) state_d = RDATA;
      RDATA: if (m_axil_rvalid) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      if (accept) begin
        grant_q <= winner;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wstrb_q <= sel_wstrb;
        aw_pend <= sel_we;
        w_pend  <= sel_we;
        ar_pend <= ~sel_we;
      end
      if (aw_pend && m_axil_awready) aw_pend <= 1'b0;
      if (w_pend && m_axil_wready)   w_pend  <= 1'b0;
      if (ar_pend && m_axil_arready) ar_pend <= 1'b0;
      if (state_q == WRESP && m_axil_bvalid) begin
        rdata_q <= '0;
        resp_q  <= m_axil_bresp;
      end
      if (state_q == RDATA && m_axil_rvalid) begin
        rdata_q <= m_axil_rdata;
        resp_q  <= m_axil_rresp;
      end
    end
  end

  assign req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = aw_pend;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = w_pend;
  assign m_axil_bready  = (state_q == WRESP);
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = ar_pend;
  assign m_axil_rready  = (state_q == RDATA);

endmodule
